// File: rtl/board_grant_responder.sv
// Per-board pending counters feeding an external round-robin arbiter;
// forwards one granted board word at a time over a valid/ready output.
module board_grant_responder #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          req_in,
  input  logic [8*DATA_W-1:0] board_data,
  output logic [7:0]          req_mask,
  output logic                arb_enable,
  input  logic [7:0]          grant_mask,
  input  logic [3:0]          grant_sel,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          out_board,
  input  logic                out_ready,
  output logic                pend_overflow
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_GNT = 2'd1;
  localparam logic [1:0] SEND     = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0] state;
  logic       hs;
  logic [7:0] ovf_hit;
  logic [2:0] gidx;
  logic       grant_ok;

  assign hs         = out_valid & out_ready;
  assign out_valid  = (state == SEND) & ~rst;
  assign arb_enable = (state == IDLE) & (|req_mask) & ~rst;

  // Accept only a consistent one-hot grant to a board that still has work.
  assign gidx     = grant_sel[2:0];
  assign grant_ok = ~grant_sel[3]
                  & (grant_mask == (8'd1 << gidx))
                  & req_mask[gidx];

  for (genvar i = 0; i < 8; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    logic             inc;
    logic             dec;

    assign inc = req_in[i];
    assign dec = hs & (out_board == 3'(i)) & (cnt != '0);
    assign ovf_hit[i] = inc & ~dec & (cnt == CNT_MAX);
    assign req_mask[i] = |cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (inc & ~dec & (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_ONE;
      end else if (dec & ~inc) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_overflow <= 1'b0;
    end else if (|ovf_hit) begin
      pend_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_data  <= '0;
      out_board <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_mask) state <= WAIT_GNT;
        end
        WAIT_GNT: begin
          if (grant_ok) begin
            out_data  <= board_data[gidx*DATA_W +: DATA_W];
            out_board <= gidx;
            state     <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_grant_responder.sv
// Directed bench for board_grant_responder with a round-robin
// arbiter model that skips the board it granted last.
module tb_board_grant_responder;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          req_in = '0;
  logic [8*DATA_W-1:0] board_data;
  logic [7:0]          req_mask;
  logic                arb_enable;
  logic [7:0]          grant_mask;
  logic [3:0]          grant_sel;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [2:0]          out_board;
  logic                out_ready = 1'b0;
  logic                pend_overflow;

  int checks = 0;
  int errors = 0;

  board_grant_responder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .req_in(req_in),
    .board_data(board_data),
    .req_mask(req_mask),
    .arb_enable(arb_enable),
    .grant_mask(grant_mask),
    .grant_sel(grant_sel),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_board(out_board),
    .out_ready(out_ready),
    .pend_overflow(pend_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0101_0011;
  endfunction

  // arbiter model
  logic [2:0] last;
  bit         last_v;
  int         nogrant;
  bit         found;
  int         pick;
  int         idx;

  always @(posedge clk) begin
    if (rst) begin
      grant_mask <= '0;
      grant_sel  <= 4'd8;
      last_v     <= 1'b0;
      last       <= '0;
      nogrant    <= 0;
    end else if (arb_enable) begin
      found = 1'b0;
      pick  = 0;
      for (int k = 0; k < 8; k++) begin
        idx = last_v ? (int'(last) + 1 + k) % 8 : k;
        if (!found && req_mask[idx] && !(last_v && idx == int'(last))) begin
          found = 1'b1;
          pick  = idx;
        end
      end
      if (found) begin
        grant_mask <= 8'(1 << pick);
        grant_sel  <= 4'(pick);
        last       <= 3'(pick);
        last_v     <= 1'b1;
      end else begin
        grant_mask <= '0;
        grant_sel  <= 4'd8;
        last_v     <= 1'b0;
        nogrant    <= nogrant + 1;
      end
    end else begin
      grant_mask <= '0;
      grant_sel  <= 4'd8;
    end
  end

  // transfer and enable monitor
  int          n_xfer;
  int          n_arb;
  logic [2:0]  xb[$];
  logic [31:0] xd[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_xfer <= n_xfer + 1;
      xb.push_back(out_board);
      xd.push_back(out_data);
    end
    if (!rst && arb_enable) n_arb <= n_arb + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_in = '0;
    step();
    step();
    rst = 1'b0;
    n_xfer = 0;
    n_arb = 0;
    xb.delete();
    xd.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || arb_enable !== 1'b0 ||
        req_mask !== 8'h00 || pend_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: valid=%b arb=%b mask=%h ovf=%b req 0 0 00 0",
               out_valid, arb_enable, req_mask, pend_overflow);
    end
    checks++;
    if (out_data !== '0 || out_board !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: data=%h board=%0d req 0 0",
               out_data, out_board);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    req_in = 8'h04;
    @(negedge clk);
    checks++;
    if (arb_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_c0_arb: got %b req 0", arb_enable);
    end
    step();
    req_in = 8'h00;
    @(negedge clk);
    checks++;
    if (req_mask !== 8'h04 || arb_enable !== 1'b1) begin
      errors++;
      $display("FAIL single_c1: mask=%h arb=%b req 04 1", req_mask, arb_enable);
    end
    step();
    @(negedge clk);
    checks++;
    if (grant_mask !== 8'h04 || arb_enable !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c2: gm=%h arb=%b valid=%b req 04 0 0",
               grant_mask, arb_enable, out_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_board !== 3'd2 || out_data !== word(2)) begin
      errors++;
      $display("FAIL single_c3: valid=%b board=%0d data=%h req 1 2 %h",
               out_valid, out_board, out_data, word(2));
    end
    step();
    @(negedge clk);
    checks++;
    if (req_mask !== 8'h00 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c4: mask=%h valid=%b req 00 0", req_mask, out_valid);
    end
  endtask

  task automatic test_two_boards();
    bit done;
    do_reset();
    out_ready = 1'b1;
    req_in = 8'h81;
    step();
    req_in = 8'h00;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (n_xfer == 2 && req_mask == 8'h00 && !out_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL two_timeout: xfers=%0d mask=%h req 2 00", n_xfer, req_mask);
    end
    checks++;
    if (n_xfer != 2 || xb.size() != 2) begin
      errors++;
      $display("FAIL two_count: got %0d req 2", n_xfer);
    end else begin
      checks++;
      if (xb[0] !== 3'd0 || xb[1] !== 3'd7) begin
        errors++;
        $display("FAIL two_order: got %0d,%0d req 0,7", xb[0], xb[1]);
      end
      checks++;
      if (xd[0] !== word(0) || xd[1] !== word(7)) begin
        errors++;
        $display("FAIL two_data: got %h,%h req %h,%h",
                 xd[0], xd[1], word(0), word(7));
      end
    end
  endtask

  task automatic test_repeat();
    bit done;
    do_reset();
    out_ready = 1'b1;
    req_in = 8'h08;
    step();
    step();
    req_in = 8'h00;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (n_xfer == 2 && req_mask == 8'h00 && !out_valid) done = 1'b1;
    end
    repeat (3) step();
    checks++;
    if (n_xfer != 2) begin
      errors++;
      $display("FAIL repeat_count: got %0d req 2", n_xfer);
    end
    checks++;
    if (n_arb != 3 || nogrant != 1) begin
      errors++;
      $display("FAIL repeat_arb: enables=%0d nogrant=%0d req 3 1", n_arb, nogrant);
    end
    checks++;
    if (xb.size() != 2 || xb[0] !== 3'd3 || xb[1] !== 3'd3) begin
      errors++;
      $display("FAIL repeat_board: size=%0d req two transfers from 3", xb.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    req_in = 8'h02;
    step();
    req_in = 8'h00;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== word(1) || out_board !== 3'd1 ||
          arb_enable !== 1'b0 || req_mask !== 8'h02) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h arb=%b mask=%h req 1 %h 0 02",
                 c, out_valid, out_data, arb_enable, req_mask, word(1));
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || n_xfer != 0) begin
      errors++;
      $display("FAIL bp_prehs: valid=%b xfers=%0d req 1 0", out_valid, n_xfer);
    end
    step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || req_mask !== 8'h00 || n_xfer != 1) begin
      errors++;
      $display("FAIL bp_after: valid=%b mask=%h xfers=%0d req 0 00 1",
               out_valid, req_mask, n_xfer);
    end
  endtask

  task automatic test_saturation();
    bit done;
    bit bad;
    do_reset();
    out_ready = 1'b0;
    req_in = 8'h20;
    repeat (15) step();
    @(negedge clk);
    checks++;
    if (pend_overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_early_ovf: got %b req 0", pend_overflow);
    end
    step();
    req_in = 8'h00;
    @(negedge clk);
    checks++;
    if (pend_overflow !== 1'b1 || out_valid !== 1'b1 || req_mask !== 8'h20) begin
      errors++;
      $display("FAIL sat_ovf: ovf=%b valid=%b mask=%h req 1 1 20",
               pend_overflow, out_valid, req_mask);
    end
    out_ready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      step();
      if (req_mask == 8'h00 && !out_valid) done = 1'b1;
    end
    repeat (4) step();
    checks++;
    if (!done || n_xfer != 15) begin
      errors++;
      $display("FAIL sat_count: done=%b xfers=%0d req 1 15", done, n_xfer);
    end
    bad = 1'b0;
    foreach (xb[k]) if (xb[k] !== 3'd5 || xd[k] !== word(5)) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL sat_board: got a transfer not from board 5 req all 5");
    end
    checks++;
    if (pend_overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky: got %b req 1", pend_overflow);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    req_in = 8'h02;
    repeat (16) step();
    req_in = 8'h00;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || pend_overflow !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: valid=%b ovf=%b req 1 1", out_valid, pend_overflow);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || req_mask !== 8'h00 ||
        pend_overflow !== 1'b0 || arb_enable !== 1'b0) begin
      errors++;
      $display("FAIL midrst: valid=%b mask=%h ovf=%b arb=%b req 0 00 0 0",
               out_valid, req_mask, pend_overflow, arb_enable);
    end
    checks++;
    if (n_xfer != 0) begin
      errors++;
      $display("FAIL midrst_xfer: got %0d req 0", n_xfer);
    end
  endtask

  task automatic test_post_reset_req();
    rst = 1'b1;
    req_in = '0;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    n_xfer = 0;
    xb.delete();
    xd.delete();
    req_in = 8'h40;
    step();
    req_in = 8'h00;
    @(negedge clk);
    checks++;
    if (req_mask !== 8'h40) begin
      errors++;
      $display("FAIL postrst_req: mask=%h req 40", req_mask);
    end
    repeat (5) step();
    checks++;
    if (n_xfer != 1 || xb.size() != 1 || xd[0] !== word(6)) begin
      errors++;
      $display("FAIL postrst_xfer: xfers=%0d req 1 from board 6", n_xfer);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) board_data[i*DATA_W +: DATA_W] = word(i);
    n_xfer = 0;
    n_arb = 0;
    test_reset();
    test_single();
    test_two_boards();
    test_repeat();
    test_backpressure();
    test_saturation();
    test_mid_reset();
    test_post_reset_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
